clk_divider_param: RTL and testbench

//  Parametrised integer clock divider: divides I_ref_clk by a runtime ratio N (2..2^RATIO_WIDTH-1).

---
 rtl/clk_divider_param.sv | 109 ++++++++++
 tb/tb_clk_divider_param.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_divider_param.sv
// -----------------------------------------------------------------------------
// clk_divider_param
//   Integer clock divider with a runtime ratio N in 2 .. 2^RATIO_WIDTH-1.
//   A new ratio or enable setting is only taken at a period boundary, so the
//   divided clock never produces runt pulses. When the divider is idle, the
//   output bypasses to I_ref_clk.
//
// Parameters
//   RATIO_WIDTH    width of I_div_ratio, the period counter and o_ratio_active
//   DUTY_ODD_HIGH  for odd N: 0 -> high phase floor(N/2), 1 -> high phase ceil(N/2)
//
// Ports
//   I_ref_clk       in   reference clock, the only clock
//   I_rst           in   synchronous active-high reset
//   I_clk_en        in   divider enable
//   I_div_ratio     in   requested ratio N; 0 or 1 selects bypass
//   o_div_clk       out  divided clock, or I_ref_clk while idle
//   o_div_tick      out  one-ref-cycle pulse aligned with each divided rising edge
//   o_ratio_active  out  ratio currently applied, 0 while idle
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | bypass: o_div_clk follows I_ref_clk, waits for a valid start
// ST_RUN  | dividing: cnt walks 0 .. active-1, decisions taken at the wrap
// -----------------------------------------------------------------------------
module clk_divider_param #(
   parameter int RATIO_WIDTH   = 8,
   parameter bit DUTY_ODD_HIGH = 1'b0
) (
   input  logic                   I_ref_clk,
   input  logic                   I_rst,
   input  logic                   I_clk_en,
   input  logic [RATIO_WIDTH-1:0] I_div_ratio,
   output logic                   o_div_clk,
   output logic                   o_div_tick,
   output logic [RATIO_WIDTH-1:0] o_ratio_active
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [RATIO_WIDTH-1:0] ONE = RATIO_WIDTH'(1);
   localparam logic [RATIO_WIDTH-1:0] TWO = RATIO_WIDTH'(2);

   logic [0:0]             state;
   logic [RATIO_WIDTH-1:0] cnt;
   logic [RATIO_WIDTH-1:0] active;
   logic                   div_q;
   logic                   tick_q;

   logic                   start;
   logic                   wrap;
   logic [RATIO_WIDTH-1:0] cnt_inc;
   logic [RATIO_WIDTH-1:0] odd_extra;
   logic [RATIO_WIDTH-1:0] high_len;

   assign start = I_clk_en && (I_div_ratio >= TWO);

   // cnt stays below active, so cnt+1 never wraps even at the maximum ratio.
   assign cnt_inc = cnt + ONE;
   assign wrap    = (cnt == (active - ONE));

   // High-phase length: floor(N/2), optionally rounded up for odd N.
   assign odd_extra = DUTY_ODD_HIGH ? {{(RATIO_WIDTH-1){1'b0}}, active[0]} : '0;
   assign high_len  = (active >> 1) + odd_extra;

   always_ff @(posedge I_ref_clk) begin
      if (I_rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         active <= '0;
         div_q  <= 1'b0;
         tick_q <= 1'b0;
      end else if (state == ST_IDLE) begin
         if (start) begin
            state  <= ST_RUN;
            active <= I_div_ratio;
            cnt    <= '0;
            div_q  <= 1'b1;
            tick_q <= 1'b1;
         end
      end else begin
         if (!wrap) begin
            cnt    <= cnt_inc;
            div_q  <= (cnt_inc < high_len);
            tick_q <= 1'b0;
         end else if (start) begin
            // Only place where a new ratio is accepted.
            active <= I_div_ratio;
            cnt    <= '0;
            div_q  <= 1'b1;
            tick_q <= 1'b1;
         end else begin
            state  <= ST_IDLE;
            cnt    <= '0;
            active <= '0;
            div_q  <= 1'b0;
            tick_q <= 1'b0;
         end
      end
   end

   // Bypass mux: the divided output is registered while running, so the only
   // combinational path is the raw reference clock while idle.
   assign o_div_clk      = (state == ST_RUN) ? div_q : I_ref_clk;
   assign o_div_tick     = tick_q;
   assign o_ratio_active = active;

endmodule

// File: tb/tb_clk_divider_param.sv
module tb_clk_divider_param;

   localparam int RW = 8;

   logic          clk;
   logic          rst;
   logic          en;
   logic [RW-1:0] ratio;

   logic          div0, tick0;
   logic [RW-1:0] act0;
   logic          div1, tick1;
   logic [RW-1:0] act1;

   int n_cmp = 0;
   int n_bad = 0;

   clk_divider_param #(.RATIO_WIDTH(RW), .DUTY_ODD_HIGH(1'b0)) dut_lo (
      .I_ref_clk     (clk),
      .I_rst         (rst),
      .I_clk_en      (en),
      .I_div_ratio   (ratio),
      .o_div_clk     (div0),
      .o_div_tick    (tick0),
      .o_ratio_active(act0)
   );

   clk_divider_param #(.RATIO_WIDTH(RW), .DUTY_ODD_HIGH(1'b1)) dut_hi (
      .I_ref_clk     (clk),
      .I_rst         (rst),
      .I_clk_en      (en),
      .I_div_ratio   (ratio),
      .o_div_clk     (div1),
      .o_div_tick    (tick1),
      .o_ratio_active(act1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: period-level view. A period of length n starts with a
   // tick, is high for the first H positions, and the input settings are only
   // looked at when the last position of a period has been played.
   bit chk_on = 0;
   bit m_run  = 0;
   int m_n    = 0;
   int m_p    = 0;

   always @(posedge clk) begin
      bit s_start;
      int s_ratio;
      int h_lo, h_hi;
      s_ratio = int'(ratio);
      s_start = en && (s_ratio >= 2);
      if (rst) begin
         m_run = 0; m_n = 0; m_p = 0; chk_on = 1;
      end else if (!m_run) begin
         if (s_start) begin
            m_run = 1; m_n = s_ratio; m_p = 0;
         end
      end else if (m_p == m_n - 1) begin
         if (s_start) begin
            m_n = s_ratio; m_p = 0;
         end else begin
            m_run = 0; m_n = 0; m_p = 0;
         end
      end else begin
         m_p = m_p + 1;
      end
      h_lo = m_n / 2;
      h_hi = (m_n + 1) / 2;
      #1;
      if (chk_on) begin
         check("div_lo",   div0,  m_run ? (m_p < h_lo) : 1);
         check("div_hi",   div1,  m_run ? (m_p < h_hi) : 1);
         check("tick_lo",  tick0, m_run && (m_p == 0));
         check("tick_hi",  tick1, m_run && (m_p == 0));
         check("ratio_lo", act0,  m_n);
         check("ratio_hi", act1,  m_n);
      end
      #6;
      if (chk_on && !m_run) begin
         check("bypass_low_lo", div0, 0);
         check("bypass_low_hi", div1, 0);
      end
   end

   task automatic capture(input int n,
                          output logic [63:0] d0, output logic [63:0] d1,
                          output logic [63:0] tk,
                          output int ones0, output int ones1, output int ticks,
                          output int r_first, output int r_last);
      d0 = '0; d1 = '0; tk = '0;
      ones0 = 0; ones1 = 0; ticks = 0; r_first = 0; r_last = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (i < 64) begin
            d0[i] = div0; d1[i] = div1; tk[i] = tick0;
         end
         ones0 += int'(div0);
         ones1 += int'(div1);
         ticks += int'(tick0);
         if (i == 0) r_first = int'(act0);
         r_last = int'(act0);
      end
   endtask

   logic [63:0] d0, d1, tk;
   int o0, o1, tc, rf, rl;

   initial begin
      rst = 1'b1; en = 1'b0; ratio = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_ratio", act0, 0);
      check("rst_tick", tick0, 0);
      check("rst_bypass_high", div0, 1);
      @(negedge clk);
      en = 1'b1; ratio = 8'd4;
      @(posedge clk); #1;
      check("rst_wins_ratio", act0, 0);
      check("rst_wins_div", div1, 1);

      // N=4
      @(negedge clk); rst = 1'b0;
      capture(8, d0, d1, tk, o0, o1, tc, rf, rl);
      check("n4_pattern", d0[7:0], 8'b0011_0011);
      check("n4_ticks",   tk[7:0], 8'b0001_0001);
      check("n4_ratio",   rl, 4);

      // N=5 both duty options, then N=2
      @(negedge clk); ratio = 8'd5;
      capture(10, d0, d1, tk, o0, o1, tc, rf, rl);
      check("n5_lo_pattern", d0[9:0], 10'b00011_00011);
      check("n5_hi_pattern", d1[9:0], 10'b00111_00111);
      check("n5_ticks",      tk[9:0], 10'b00001_00001);
      @(negedge clk); ratio = 8'd2;
      capture(6, d0, d1, tk, o0, o1, tc, rf, rl);
      check("n2_pattern", d0[5:0], 6'b010101);
      check("n2_ticks",   tk[5:0], 6'b010101);

      // Ratio change mid-period only lands at the wrap
      @(negedge clk); ratio = 8'd4;
      capture(2, d0, d1, tk, o0, o1, tc, rf, rl);
      @(negedge clk); ratio = 8'd6;
      capture(2, d0, d1, tk, o0, o1, tc, rf, rl);
      check("chg_old_tail", d0[1:0], 2'b00);
      check("chg_old_ratio", rl, 4);
      capture(6, d0, d1, tk, o0, o1, tc, rf, rl);
      check("chg_new_first_ratio", rf, 6);
      check("chg_new_pattern", d0[5:0], 6'b000111);
      check("chg_new_ticks", tk[5:0], 6'b000001);

      // Enable drop at cnt=2 of N=6
      capture(3, d0, d1, tk, o0, o1, tc, rf, rl);
      check("en_drop_head", d0[2:0], 3'b111);
      @(negedge clk); en = 1'b0;
      capture(3, d0, d1, tk, o0, o1, tc, rf, rl);
      check("en_drop_tail", d0[2:0], 3'b000);
      check("en_drop_tail_ratio", rl, 6);
      capture(2, d0, d1, tk, o0, o1, tc, rf, rl);
      check("en_drop_bypass", d0[1:0], 2'b11);
      check("en_drop_idle_ratio", rf, 0);

      // Ratio 1 and 0 with enable never run
      @(negedge clk); en = 1'b1; ratio = 8'd1;
      capture(3, d0, d1, tk, o0, o1, tc, rf, rl);
      check("r1_ratio", rl, 0);
      check("r1_ticks", tc, 0);
      @(negedge clk); ratio = 8'd0;
      capture(2, d0, d1, tk, o0, o1, tc, rf, rl);
      check("r0_ratio", rl, 0);
      check("r0_ticks", tc, 0);

      // Reset in the high phase of N=8
      @(negedge clk); ratio = 8'd8;
      capture(2, d0, d1, tk, o0, o1, tc, rf, rl);
      check("n8_head", d0[1:0], 2'b11);
      check("n8_ratio", rl, 8);
      @(negedge clk); rst = 1'b1;
      capture(1, d0, d1, tk, o0, o1, tc, rf, rl);
      check("mid_rst_ratio", rl, 0);
      check("mid_rst_tick", tc, 0);

      // N=255, maximum ratio
      @(negedge clk); rst = 1'b0; ratio = 8'd255;
      capture(255, d0, d1, tk, o0, o1, tc, rf, rl);
      check("n255_high_lo", o0, 127);
      check("n255_high_hi", o1, 128);
      check("n255_ticks", tc, 1);
      check("n255_head", d0, 64'hFFFF_FFFF_FFFF_FFFF);
      check("n255_ratio", rl, 255);
      capture(1, d0, d1, tk, o0, o1, tc, rf, rl);
      check("n255_rewrap_tick", tc, 1);

      // Randomized phase, checked by the model every cycle
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 199) == 0);
         en  = ($urandom_range(0, 19) != 0);
         if ($urandom_range(0, 9) == 0) begin
            if ($urandom_range(0, 9) < 8) ratio = RW'($urandom_range(0, 9));
            else                          ratio = RW'($urandom_range(0, 255));
         end
      end
      @(posedge clk); #8;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
